// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: drives the RAM datapath control word through
// ADDR -> WRITE/READ -> WB -> DONE for one LDUR/STUR-style access at a time.
module mem_access_sequencer #(
  parameter logic [4:0] FS_ADD   = 5'b01000,
  parameter int          OFFSET_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_store,
  input  logic [4:0]          rn,
  input  logic [4:0]          rt,
  input  logic [OFFSET_W-1:0] offset,
  output logic                busy,
  output logic                done,
  output logic                W,
  output logic                EN_B,
  output logic                EN_ALU,
  output logic                EN_ADDR,
  output logic                K_SEL,
  output logic                PC_SEL,
  output logic                C0,
  output logic                CS,
  output logic                WE,
  output logic                OE,
  output logic [4:0]          SA,
  output logic [4:0]          SB,
  output logic [4:0]          DA,
  output logic [4:0]          FS,
  output logic [63:0]         K,
  output logic [2:0]          state_dbg
);

  // Handshake: start acts as a valid strobe that is taken only while busy is
  // low (ready = ~busy); it is never queued. done pulses once per completed
  // access and is suppressed when reset aborts the access.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_WB    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                store_q, store_d;
  logic [4:0]          rn_q, rn_d;
  logic [4:0]          rt_q, rt_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic                accept;

  assign accept    = (state_q == S_IDLE) && start;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      rn_q    <= '0;
      rt_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      rn_q    <= rn_d;
      rt_q    <= rt_d;
      off_q   <= off_d;
    end
  end

  // Request fields are frozen at acceptance so input churn cannot disturb an access.
  always_comb begin
    store_d = store_q;
    rn_d    = rn_q;
    rt_d    = rt_q;
    off_d   = off_q;
    if (accept) begin
      store_d = is_store;
      rn_d    = rn;
      rt_d    = rt;
      off_d   = offset;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADDR;
      S_ADDR:  state_d = store_q ? S_WRITE : S_READ;
      S_WRITE: state_d = S_DONE;
      S_READ:  state_d = S_WB;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    W       = 1'b0;
    EN_B    = 1'b0;
    EN_ALU  = 1'b0;
    EN_ADDR = 1'b0;
    K_SEL   = 1'b0;
    PC_SEL  = 1'b0;
    C0      = 1'b0;
    CS      = 1'b0;
    WE      = 1'b0;
    OE      = 1'b0;
    SA      = '0;
    SB      = '0;
    DA      = '0;
    FS      = '0;
    K       = '0;
    // The effective address Rn + sext(offset) stays on the address bus for the whole access.
    if (state_q inside {S_ADDR, S_WRITE, S_READ, S_WB}) begin
      SA      = rn_q;
      K_SEL   = 1'b1;
      K       = {{(64-OFFSET_W){off_q[OFFSET_W-1]}}, off_q};
      FS      = FS_ADD;
      EN_ADDR = 1'b1;
    end
    case (state_q)
      S_WRITE: begin
        CS   = 1'b1;
        WE   = 1'b1;
        SB   = rt_q;
        EN_B = 1'b1;
      end
      S_READ: begin
        CS = 1'b1;
        OE = 1'b1;
      end
      S_WB: begin
        CS = 1'b1;
        OE = 1'b1;
        W  = 1'b1;
        DA = rt_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: a small regfile/RAM datapath obeys the DUT's
// control word; an access-level reference model feeds a done-time scoreboard.
module tb_mem_access_sequencer;

  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam int         OFFSET_W = 9;
  localparam int         EW       = 77;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, start, is_store;
  logic [4:0]          rn, rt;
  logic [OFFSET_W-1:0] offset;
  logic                busy, done, W, EN_B, EN_ALU, EN_ADDR, K_SEL, PC_SEL, C0, CS, WE, OE;
  logic [4:0]          SA, SB, DA, FS;
  logic [63:0]         K;
  logic [2:0]          state_dbg;

  mem_access_sequencer #(.FS_ADD(FS_ADD), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .rn(rn), .rt(rt), .offset(offset),
    .busy(busy), .done(done), .W(W), .EN_B(EN_B), .EN_ALU(EN_ALU),
    .EN_ADDR(EN_ADDR), .K_SEL(K_SEL), .PC_SEL(PC_SEL), .C0(C0),
    .CS(CS), .WE(WE), .OE(OE), .SA(SA), .SB(SB), .DA(DA), .FS(FS),
    .K(K), .state_dbg(state_dbg)
  );

  // Backdoor loads into datapath and reference at the same edge.
  logic        bd_reg_we = 1'b0, bd_ram_we = 1'b0, bd_clear = 1'b0;
  logic [11:0] bd_idx = '0;
  logic [63:0] bd_val = '0;

  logic [63:0] dp_reg [32];
  logic [63:0] dp_ram [4096];
  logic [63:0] ram_rdata;
  logic [63:0] alu_b, addr_bus, data_bus;

  assign alu_b    = K_SEL ? K : dp_reg[SB];
  assign addr_bus = (EN_ADDR && FS == FS_ADD) ? dp_reg[SA] + alu_b : 64'h0;
  assign data_bus = EN_B ? dp_reg[SB] : ((CS && OE && !WE) ? ram_rdata : 64'h0);

  always @(posedge clk) begin
    if (bd_clear) begin
      for (int i = 0; i < 32; i++) dp_reg[i] <= 64'h0;
      for (int i = 0; i < 4096; i++) dp_ram[i] <= 64'h0;
      ram_rdata <= 64'h0;
    end
    if (bd_reg_we) dp_reg[bd_idx[4:0]] <= bd_val;
    if (bd_ram_we) dp_ram[bd_idx] <= bd_val;
    if (CS && WE) dp_ram[addr_bus[11:0]] <= data_bus;
    if (CS && OE && !WE) ram_rdata <= dp_ram[addr_bus[11:0]];
    if (W) dp_reg[DA] <= data_bus;
  end

  // Access-level reference: memory/register effects plus the cycle index of the access.
  logic [63:0]         ref_reg [32];
  logic [63:0]         ref_ram [4096];
  logic                m_active = 1'b0, m_store = 1'b0;
  int                  m_phase = 0;
  logic [4:0]          m_rn = '0, m_rt = '0;
  logic [OFFSET_W-1:0] m_off = '0;
  logic [EW-1:0]       exp_q[$];

  function automatic logic [63:0] sext(input logic [OFFSET_W-1:0] o);
    return {{(64-OFFSET_W){o[OFFSET_W-1]}}, o};
  endfunction

  always @(posedge clk) begin
    logic [11:0] ea;
    if (bd_clear) begin
      for (int i = 0; i < 32; i++) ref_reg[i] = 64'h0;
      for (int i = 0; i < 4096; i++) ref_ram[i] = 64'h0;
    end
    if (bd_reg_we) ref_reg[bd_idx[4:0]] = bd_val;
    if (bd_ram_we) ref_ram[bd_idx] = bd_val;
    if (m_active) begin
      ea = 12'(ref_reg[m_rn] + sext(m_off));
      if (m_store && m_phase == 2) begin
        ref_ram[ea] = ref_reg[m_rt];
        if (!rst) exp_q.push_back({1'b1, ea, ref_reg[m_rt]});
      end
      if (!m_store && m_phase == 3) begin
        ref_reg[m_rt] = ref_ram[ea];
        if (!rst) exp_q.push_back({1'b0, 7'h0, m_rt, ref_ram[ea]});
      end
    end
    if (rst) begin
      m_active = 1'b0;
      m_phase  = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_phase  = 1;
        m_store  = is_store;
        m_rn     = rn;
        m_rt     = rt;
        m_off    = offset;
      end
    end else if (m_phase == (m_store ? 3 : 4)) begin
      m_active = 1'b0;
      m_phase  = 0;
    end else begin
      m_phase++;
    end
  end

  function automatic logic [95:0] exp_ctrl();
    logic       b, d, w, enb, enaddr, ksel, cs, we, oe;
    logic [4:0] sa, sb, da, fs;
    logic [63:0] k;
    {b, d, w, enb, enaddr, ksel, cs, we, oe} = '0;
    {sa, sb, da, fs} = '0;
    k = '0;
    if (m_active) begin
      b = 1'b1;
      if (m_phase == (m_store ? 3 : 4)) d = 1'b1;
      else begin
        sa = m_rn; ksel = 1'b1; k = sext(m_off); fs = FS_ADD; enaddr = 1'b1;
        if (m_store && m_phase == 2) begin cs = 1'b1; we = 1'b1; sb = m_rt; enb = 1'b1; end
        if (!m_store && m_phase >= 2) begin
          cs = 1'b1; oe = 1'b1;
          if (m_phase == 3) begin w = 1'b1; da = m_rt; end
        end
      end
    end
    return {b, d, w, enb, 1'b0, enaddr, ksel, 1'b0, 1'b0, cs, we, oe, sa, sb, da, fs, k};
  endfunction

  int   n_vec = 0, n_err = 0;
  logic chk_en = 1'b0;

  // Monitor: full control word every cycle, scoreboard pop on every done pulse.
  always @(negedge clk) begin
    logic [95:0]   act, exp;
    logic [EW-1:0] e;
    logic [63:0]   got;
    if (chk_en) begin
      act = {busy, done, W, EN_B, EN_ALU, EN_ADDR, K_SEL, PC_SEL, C0, CS, WE, OE, SA, SB, DA, FS, K};
      exp = exp_ctrl();
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL ctrl t=%0t state=%0d got=%h exp=%h", $time, state_dbg, act, exp);
      end
      n_vec++;
      if (EN_B && CS && OE && !WE) begin
        n_err++;
        $display("FAIL bus_contention t=%0t EN_B=%b CS=%b OE=%b WE=%b exp no overlap", $time, EN_B, CS, OE, WE);
      end
      if (done) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL done_unexpected t=%0t got done=1 exp no pending access", $time);
        end else begin
          e   = exp_q.pop_front();
          got = e[76] ? dp_ram[e[75:64]] : dp_reg[e[68:64]];
          if (got !== e[63:0]) begin
            n_err++;
            $display("FAIL %s_result t=%0t idx=%h got=%h exp=%h", e[76] ? "store" : "load",
                     $time, e[75:64], got, e[63:0]);
          end
        end
      end
    end
  end

  task automatic set_reg(input logic [4:0] i, input logic [63:0] v);
    @(negedge clk); bd_reg_we = 1'b1; bd_idx = {7'h0, i}; bd_val = v;
    @(negedge clk); bd_reg_we = 1'b0;
  endtask

  task automatic set_ram(input logic [11:0] a, input logic [63:0] v);
    @(negedge clk); bd_ram_we = 1'b1; bd_idx = a; bd_val = v;
    @(negedge clk); bd_ram_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_active && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (m_active) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout t=%0t got busy after %0d cycles exp idle", $time, n);
    end
    @(negedge clk);
  endtask

  // Leaves the bench at the falling edge of the ADDR cycle with junk on the inputs.
  task automatic issue(input logic st, input logic [4:0] a, input logic [4:0] t,
                       input logic [OFFSET_W-1:0] o, input logic wait_done);
    @(negedge clk);
    start = 1'b1; is_store = st; rn = a; rt = t; offset = o;
    @(negedge clk);
    start = 1'b0;
    is_store = 1'($urandom_range(0, 1));
    rn = 5'($urandom_range(0, 31));
    rt = 5'($urandom_range(0, 31));
    offset = OFFSET_W'($urandom);
    if (wait_done) wait_idle();
  endtask

  initial begin
    logic [63:0] keep;
    int          bad_r, bad_m;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; rn = '0; rt = '0; offset = '0;
    @(negedge clk); bd_clear = 1'b1;
    @(negedge clk); bd_clear = 1'b0;
    @(negedge clk); chk_en = 1'b1;
    @(negedge clk); rst = 1'b0;

    set_reg(5'd1, 64'h100);
    set_reg(5'd2, 64'hDEADBEEF_CAFEF00D);
    issue(1'b1, 5'd1, 5'd2, 9'sd8, 1'b1);
    issue(1'b0, 5'd1, 5'd3, 9'sd8, 1'b1);

    // Negative offset, then modulo-4096 wrap, then reload both.
    set_reg(5'd1, 64'd16);
    set_reg(5'd6, 64'h0123_4567_89AB_CDEF);
    issue(1'b1, 5'd1, 5'd6, -9'sd8, 1'b1);
    set_reg(5'd1, 64'd4090);
    set_reg(5'd6, 64'hFEED_FACE_0000_1111);
    issue(1'b1, 5'd1, 5'd6, 9'sd10, 1'b1);
    set_reg(5'd1, 64'd16);
    issue(1'b0, 5'd1, 5'd7, -9'sd8, 1'b1);
    set_reg(5'd1, 64'd4090);
    issue(1'b0, 5'd1, 5'd8, 9'sd10, 1'b1);

    set_reg(5'd4, 64'h20);
    set_ram(12'h020, 64'h55);
    issue(1'b0, 5'd4, 5'd4, 9'sd0, 1'b1);

    // Re-strobes while busy must be ignored.
    issue(1'b0, 5'd1, 5'd9, 9'sd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; is_store = 1'b1; rt = 5'd10 + 5'(i);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Reset lands on the edge closing READ: no write-back, no done.
    set_reg(5'd11, 64'hAAAA_5555_AAAA_5555);
    keep = 64'hAAAA_5555_AAAA_5555;
    issue(1'b0, 5'd1, 5'd11, 9'sd10, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_vec++;
    if (dp_reg[11] !== keep) begin
      n_err++;
      $display("FAIL abort_rt got=%h exp=%h", dp_reg[11], keep);
    end
    issue(1'b1, 5'd4, 5'd2, 9'sd16, 1'b1);

    // Reset and start at the same edge: request dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; is_store = 1'b1; rn = 5'd1; rt = 5'd2; offset = '0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 1; i <= 8; i++) set_reg(5'(i), {$urandom, $urandom});
    for (int n = 0; n < 40; n++) begin
      logic st;
      logic [4:0] a, t;
      st = 1'($urandom_range(0, 1));
      a  = 5'($urandom_range(1, 8));
      t  = 5'($urandom_range(1, 8));
      if ($urandom_range(0, 7) == 0) begin
        issue(st, a, t, OFFSET_W'($urandom), 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
      end else begin
        issue(st, a, t, OFFSET_W'($urandom), 1'b1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    bad_r = 0;
    bad_m = 0;
    for (int i = 0; i < 32; i++) if (dp_reg[i] !== ref_reg[i]) bad_r++;
    for (int i = 0; i < 4096; i++) if (dp_ram[i] !== ref_ram[i]) bad_m++;
    n_vec++;
    if (bad_r != 0) begin
      n_err++;
      $display("FAIL final_regs got %0d differing registers exp 0", bad_r);
    end
    n_vec++;
    if (bad_m != 0) begin
      n_err++;
      $display("FAIL final_ram got %0d differing words exp 0", bad_m);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_done got %0d pending accesses exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Multi-cycle control sequencer that issues LDUR/STUR-style memory transactions by driving the control word of the RAM datapath (regfile, ALU, 64-bit data bus, address bus, single-port synchronous-read RAM). It accepts one load or store request at a time, holds the effective-address computation (Rn + sign-extended offset) on the address bus for the whole access, and sequences the RAM chip-select, write-enable and output-enable signals. It also sequences the regfile write-back and bus tristate enables. It signals completion with a one-cycle `done` pulse.

## Interface
- `FS_ADD`, 5'b01000, ALU function-select code for A+B
- `OFFSET_W`, 9, width of signed immediate offset
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request strobe; sampled only in IDLE
- `is_store`  in  1  1 = store Rt to memory, 0 = load memory into Rt
- `rn`  in  5  base register address
- `rt`  in  5  data register (store source / load destination)
- `offset`  in  OFFSET_W  signed byte offset, two's complement
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `W, EN_B, EN_ALU, EN_ADDR, K_SEL, PC_SEL, C0, CS, WE, OE`  out  1 each  datapath control bits, same meaning as the datapath ports
- `SA, SB, DA, FS`  out  5 each  regfile read A/B, write address, ALU function
- `K`  out  64  constant to ALU B-input mux

## Operation
- States: IDLE, ADDR, WRITE, READ, WB, DONE.
- IDLE: all control outputs 0, `SA/SB/DA/FS`=0, `K`=0, `busy`=0, `done`=0. `start`=1 captures `is_store, rn, rt, offset` into internal registers and moves to ADDR.
- In ADDR, WRITE, READ and WB, the following are driven from the captured registers and held constant: `SA`=rn, `K_SEL`=1, `K`=sign-extend(offset) to 64 bits, `FS`=FS_ADD, `C0`=0, `EN_ADDR`=1.
- ADDR: `CS`=`WE`=`OE`=0. Address setup cycle. Next state is WRITE if store, otherwise READ.
- WRITE: `CS`=1, `WE`=1, `OE`=0, `SB`=rt, `EN_B`=1. The RAM writes Rt at the closing edge. Next state is DONE.
- READ: `CS`=1, `WE`=0, `OE`=1, `EN_B`=0, `EN_ALU`=0. The RAM registers read data at the closing edge. Next state is WB.
- WB: `CS`=1, `OE`=1, `WE`=0 (RAM drives the data bus), `W`=1, `DA`=rt, `EN_B`=`EN_ALU`=0. The regfile captures the data bus at the closing edge. Next state is DONE.
- DONE: all control outputs return to their IDLE values, `done`=1, `busy`=1. Next state is IDLE.
- `EN_ALU`, `PC_SEL` and `C0` are 0 in every state. `EN_B` and the RAM output drive (`CS&OE&~WE`) are never both active in the same cycle, so there is no data-bus contention.
- `start` while busy is ignored. It is not queued.
- Effective address is 64-bit wraparound addition. The RAM sees only ADDR[11:0], so the memory address wraps modulo 4096.
- Rn, Rt and offset changes on the inputs after capture have no effect on an in-flight access.
- rn == rt is legal. For a load, the address uses the pre-load Rn value because `SA` is read before WB commits.

## Timing
- All outputs are registered, or decoded from state plus captured registers only. There is no combinational path from `start` to any output.
- Store latency: `start` sampled at edge 0 → ADDR cycle 1 → WRITE cycle 2 → `done` in cycle 3 → IDLE in cycle 4. The earliest next `start` is accepted at the edge ending cycle 3 + 1, i.e. in IDLE at cycle 4.
- Load latency: ADDR cycle 1, READ cycle 2, WB cycle 3, `done` cycle 4. The loaded value is readable from the regfile in cycle 4.
- Reset: `rst`=1 at an edge forces IDLE and all outputs to their IDLE values in the following cycle, from any state, including mid-WRITE and mid-WB.
  - If reset hits WRITE, the memory write of that edge still completes, because WE is already asserted.
  - `done` is not produced for an aborted access.
- `rst` and `start` asserted at the same edge: reset wins, and the request is dropped.

## Test plan
- Store: R1=0x100, R2=0xDEADBEEF_CAFEF00D, start store rn=1 rt=2 offset=+8 → `done` in cycle 3. RAM[0x108] = 0xDEADBEEF_CAFEF00D. Regfile unchanged.
- Load: after the store above, start load rn=1 rt=3 offset=+8 → `done` in cycle 4. R3 = 0xDEADBEEF_CAFEF00D. No cycle with both `EN_B` and `OE&CS` high.
- Negative offset and wrap: R1=16, offset=-8 stores to RAM[8]. R1=4090, offset=+10 stores to RAM[4]. Reload both addresses and confirm the values.
- Load with rn==rt: R4=0x20, RAM[0x20]=0x55, load rn=4 rt=4 offset=0 → R4=0x55.
- Busy/ignore: pulse `start` again in cycles 1–3 of a load with different rt. Only the first access occurs, and exactly one `done` pulse is seen.
- Reset mid-load: assert `rst` during READ → all outputs 0 the next cycle, `busy`=0, no `done`, destination register unchanged. A subsequent store completes normally.
